neural_layer_engine: RTL and testbench
======================================

NEURAL_LAYER_ENGINE -- requirements
Module: neural_layer_engine

Interface
REQ-001 Parameter DATA_W, default 8: signed fixed-point width of inputs, weights and results.
REQ-002 Parameter FRAC_W, default 4: fractional bits of the fixed-point format.
REQ-003 Parameter N_IN, default 4: inputs per neuron; range 1..16.
REQ-004 Parameter N_OUT, default 4: neurons (result words) per layer; range 1..16.
REQ-005 Parameter ADDR_W, default 8: width of all address ports.
REQ-006 Parameter RESULT_BASE, default 8'h80: base address reported for the result block.
REQ-007 clk  input  1  the single clock; all state updates on its rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 wr_en  input  1  load strobe for input/weight memory.
REQ-010 wr_addr  input  ADDR_W  load address.
REQ-011 wr_data  input  DATA_W  load data.
REQ-012 start  input  1  single-cycle request to evaluate the layer.
REQ-013 rd_addr  input  ADDR_W  result read index, 0..N_OUT-1.
REQ-014 busy  output  1  high while evaluating.
REQ-015 finished  output  1  high from layer completion until the next accepted start.
REQ-016 result_base_address  output  ADDR_W  constant RESULT_BASE.
REQ-017 result_word_count  output  ADDR_W  constant N_OUT.
REQ-018 data_out  output  DATA_W  result word at rd_addr; combinational read.

Function
REQ-019 Load map: addresses 0..N_IN-1 hold inputs x[i]; address N_IN + n*N_IN + i holds weight w[n][i]; a write to any other address is ignored.
REQ-020 Writes with wr_en high while busy is high are ignored.
REQ-021 FSM states IDLE, MAC, STORE, DONE; start in IDLE or DONE moves to MAC with neuron index n=0, input index i=0, accumulator cleared, finished cleared.
REQ-022 start while busy is ignored; busy is high in MAC and STORE only.
REQ-023 MAC: one product x[i]*w[n][i] added per cycle for N_IN cycles, then STORE.
REQ-024 Accumulator width 2*DATA_W+4, signed; no overflow possible within the parameter range.
REQ-025 STORE: accumulator arithmetic-shifted right by FRAC_W, saturated to the signed DATA_W range, activated per REQ-034, written to result[n]; accumulator cleared.
REQ-026 After STORE: if n < N_OUT-1 then n increments and MAC resumes; otherwise DONE.
REQ-027 finished rises exactly N_OUT*(N_IN+1) cycles after the edge that samples start; it is held in DONE.
REQ-028 rd_addr >= N_OUT makes data_out read 0.
REQ-029 Result memory retains its contents across evaluations and is rewritten only in STORE.

Reset
REQ-030 reset low forces IDLE, busy=0, finished=0, n=0, i=0, accumulator=0, independent of clk.
REQ-031 A reset during MAC or STORE aborts the evaluation; no further result words are written.
REQ-032 Input, weight and result memories are not cleared by reset; a bench reads them only after a write or completed evaluation.
REQ-033 result_base_address and result_word_count hold their constants during and after reset.

Configuration
REQ-034 Macro NEURAL_RELU_EN defined: STORE applies ReLU, writing 0 for a negative saturated value; undefined: saturated value written unchanged (identity activation).

Verification
REQ-035 Defaults, all x=0x10, all w=0x10, start -> finished after 20 cycles, result[0..3]=0x40, result_word_count=4, result_base_address=0x80.
REQ-036 All x=0x7F, all w=0x7F -> result words saturate to 0x7F; x=0x7F, w=0x81 -> 0x80 (undefined macro) or 0x00 (NEURAL_RELU_EN).
REQ-037 x=0x10, w[1][*]=0xF0, other weights 0x10 -> result[1]=0xC0 without macro, 0x00 with NEURAL_RELU_EN; result[0]=0x40.
REQ-038 Second start pulse and wr_en writes during busy -> no restart, memories unchanged, finished after the original 20 cycles.
REQ-039 reset asserted low at cycle 7 after start -> busy=0, finished=0 immediately; new start gives full correct results after 20 cycles.
REQ-040 rd_addr=4 with N_OUT=4 -> data_out=0; wr_addr=0x40 write ignored (no memory change).

Source files
------------

// File: rtl/neural_layer_engine.sv
// Fixed-point dense layer: N_OUT neurons, each a signed MAC over N_IN loaded inputs/weights.
// Optional ReLU activation when NEURAL_RELU_EN is defined; identity activation otherwise.
module neural_layer_engine #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 4,
  parameter int N_IN   = 4,
  parameter int N_OUT  = 4,
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESULT_BASE = 8'h80
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              finished,
  output logic [ADDR_W-1:0] result_base_address,
  output logic [ADDR_W-1:0] result_word_count,
  output logic [DATA_W-1:0] data_out
);

  // state | meaning
  // IDLE  | no evaluation since reset
  // MAC   | accumulate x[i]*w[n][i], one term per cycle
  // STORE | scale, saturate, activate and write result[n]
  // DONE  | layer complete, results valid
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MAC   = 2'd1;
  localparam logic [1:0] STORE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int ACC_W = 2*DATA_W + 4;
  localparam int CNT_W = 5;
  localparam int N_W   = N_IN*N_OUT;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        n_q, n_d;
  logic [CNT_W-1:0]        i_q, i_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  logic [DATA_W-1:0] x_mem_q   [N_IN];
  logic [DATA_W-1:0] w_mem_q   [N_W];
  logic [DATA_W-1:0] res_mem_q [N_OUT];

  logic              wr_ok;
  logic [31:0]       wa;
  logic [N_IN-1:0]   x_we;
  logic [N_W-1:0]    w_we;
  logic              res_we;
  logic [31:0]       w_idx;

  logic signed [DATA_W-1:0] x_sel, w_sel;
  logic signed [ACC_W-1:0]  x_ext, w_ext, prod;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] sat_val;
  logic [DATA_W-1:0]        act_val;

  assign busy                = (state_q == MAC) || (state_q == STORE);
  assign finished            = (state_q == DONE);
  assign result_base_address = RESULT_BASE;
  assign result_word_count   = ADDR_W'(N_OUT);

  // Load-port decode; out-of-map addresses match no entry and are dropped
  assign wr_ok = wr_en && !busy;
  assign wa    = 32'(wr_addr);

  always_comb begin
    x_we = '0;
    w_we = '0;
    for (int k = 0; k < N_IN; k++)
      x_we[k] = wr_ok && (wa == 32'(k));
    for (int k = 0; k < N_W; k++)
      w_we[k] = wr_ok && (wa == 32'(N_IN + k));
  end

  assign w_idx = 32'(n_q) * 32'(N_IN) + 32'(i_q);

  always_comb begin
    x_sel = '0;
    w_sel = '0;
    for (int k = 0; k < N_IN; k++)
      if (i_q == CNT_W'(k)) x_sel = x_mem_q[k];
    for (int k = 0; k < N_W; k++)
      if (w_idx == 32'(k)) w_sel = w_mem_q[k];
  end

  assign x_ext = {{(ACC_W-DATA_W){x_sel[DATA_W-1]}}, x_sel};
  assign w_ext = {{(ACC_W-DATA_W){w_sel[DATA_W-1]}}, w_sel};
  assign prod  = x_ext * w_ext;

  assign shifted = acc_q >>> FRAC_W;

  always_comb begin
    if (shifted > SAT_MAX)      sat_val = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN) sat_val = SAT_MIN[DATA_W-1:0];
    else                        sat_val = shifted[DATA_W-1:0];
  end

`ifdef NEURAL_RELU_EN
  assign act_val = sat_val[DATA_W-1] ? '0 : sat_val;
`else
  assign act_val = sat_val;
`endif

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    acc_d   = acc_q;
    res_we  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = MAC;
          n_d     = '0;
          i_d     = '0;
          acc_d   = '0;
        end
      end
      MAC: begin
        acc_d = acc_q + prod;
        if (i_q == CNT_W'(N_IN-1)) begin
          i_d     = '0;
          state_d = STORE;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      STORE: begin
        res_we = 1'b1;
        acc_d  = '0;
        if (n_q == CNT_W'(N_OUT-1)) begin
          state_d = DONE;
        end else begin
          n_d     = n_q + 1'b1;
          state_d = MAC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      i_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      acc_q   <= acc_d;
    end
  end

  // Storage arrays are deliberately left out of reset
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_IN; k++)
      if (x_we[k]) x_mem_q[k] <= wr_data;
    for (int k = 0; k < N_W; k++)
      if (w_we[k]) w_mem_q[k] <= wr_data;
    for (int k = 0; k < N_OUT; k++)
      if (res_we && (n_q == CNT_W'(k))) res_mem_q[k] <= act_val;
  end

  always_comb begin
    data_out = '0;
    for (int k = 0; k < N_OUT; k++)
      if (rd_addr == ADDR_W'(k)) data_out = res_mem_q[k];
  end

endmodule

// File: tb/tb_neural_layer_engine.sv
// Bench for neural_layer_engine: directed corner cases plus random layers
// checked against an integer-arithmetic reference model.
module tb_neural_layer_engine;

  localparam int DATA_W = 8;
  localparam int FRAC_W = 4;
  localparam int N_IN   = 4;
  localparam int N_OUT  = 4;
  localparam int ADDR_W = 8;
  localparam int LAT    = N_OUT*(N_IN+1);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              busy, finished;
  logic [ADDR_W-1:0] result_base_address, result_word_count;
  logic [DATA_W-1:0] data_out;

  int n_tests = 0;
  int n_fail  = 0;

  int mx [N_IN];
  int mw [N_OUT][N_IN];

  neural_layer_engine #(
    .DATA_W(DATA_W), .FRAC_W(FRAC_W), .N_IN(N_IN), .N_OUT(N_OUT),
    .ADDR_W(ADDR_W), .RESULT_BASE(8'h80)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .rd_addr(rd_addr), .busy(busy), .finished(finished),
    .result_base_address(result_base_address), .result_word_count(result_word_count),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int s8(input logic [7:0] b);
    return int'($signed(b));
  endfunction

  // Reference: dot product, floor-scale by 2^FRAC_W, clamp, optional ReLU
  function automatic logic [7:0] model_out(input int n);
    int acc;
    acc = 0;
    for (int i = 0; i < N_IN; i++) acc += mx[i] * mw[n][i];
    acc = acc >>> FRAC_W;
    if (acc > 127)  acc = 127;
    if (acc < -128) acc = -128;
`ifdef NEURAL_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return 8'(acc);
  endfunction

  task automatic write_word(input int addr, input logic [7:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 8'(addr); wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    if (addr < N_IN) mx[addr] = s8(data);
    else if (addr < N_IN + N_IN*N_OUT) mw[(addr-N_IN)/N_IN][(addr-N_IN)%N_IN] = s8(data);
  endtask

  task automatic load_all(input logic [7:0] xv, input logic [7:0] wv);
    for (int i = 0; i < N_IN; i++) write_word(i, xv);
    for (int k = 0; k < N_IN*N_OUT; k++) write_word(N_IN + k, wv);
  endtask

  task automatic read_results(input string tag);
    for (int n = 0; n < N_OUT; n++) begin
      rd_addr = 8'(n);
      #1;
      check($sformatf("%s_res%0d", tag, n), 32'(data_out), 32'(model_out(n)));
    end
  endtask

  // disturb: mid-evaluation start pulse and load write, both must be ignored
  task automatic run_layer(input string tag, input bit disturb);
    int cycles;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    cycles = 0;
    while (!finished && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (disturb && cycles == 5) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 8'd0; wr_data = ~8'(mx[0]);
      end else if (disturb && cycles == 6) begin
        start = 1'b0; wr_en = 1'b0;
      end
    end
    check({tag, "_latency"}, 32'(cycles), 32'(LAT));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    read_results(tag);
  endtask

  initial begin
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_finished", 32'(finished), 32'd0);
    check("rst_base", 32'(result_base_address), 32'h80);
    check("rst_count", 32'(result_word_count), 32'(N_OUT));
    reset = 1'b1;

    load_all(8'h10, 8'h10);
    run_layer("unity", 1'b0);
    rd_addr = 8'd0; #1;
    check("unity_abs0", 32'(data_out), 32'h40);
    check("count", 32'(result_word_count), 32'd4);

    load_all(8'h7F, 8'h7F);
    run_layer("satpos", 1'b0);
    rd_addr = 8'd2; #1;
    check("satpos_abs", 32'(data_out), 32'h7F);

    load_all(8'h7F, 8'h81);
    run_layer("satneg", 1'b0);
    rd_addr = 8'd3; #1;
`ifdef NEURAL_RELU_EN
    check("satneg_abs", 32'(data_out), 32'h00);
`else
    check("satneg_abs", 32'(data_out), 32'h80);
`endif

    load_all(8'h10, 8'h10);
    for (int i = 0; i < N_IN; i++) write_word(N_IN + N_IN + i, 8'hF0);
    run_layer("negn1", 1'b0);
    rd_addr = 8'd1; #1;
`ifdef NEURAL_RELU_EN
    check("negn1_abs1", 32'(data_out), 32'h00);
`else
    check("negn1_abs1", 32'(data_out), 32'hC0);
`endif
    rd_addr = 8'd0; #1;
    check("negn1_abs0", 32'(data_out), 32'h40);

    run_layer("disturb", 1'b1);
    rd_addr = 8'd1; #1;
`ifdef NEURAL_RELU_EN
    check("disturb_abs1", 32'(data_out), 32'h00);
`else
    check("disturb_abs1", 32'(data_out), 32'hC0);
`endif

    for (int t = 0; t < 5; t++) begin
      for (int a = 0; a < N_IN + N_IN*N_OUT; a++) write_word(a, 8'($urandom_range(0, 255)));
      run_layer($sformatf("rnd%0d", t), 1'b0);
    end

    // Abort mid-evaluation with reset, then re-run on fresh data
    load_all(8'h10, 8'h10);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_finished", 32'(finished), 32'd0);
    check("abort_base", 32'(result_base_address), 32'h80);
    @(negedge clk); reset = 1'b1;
    for (int a = 0; a < N_IN + N_IN*N_OUT; a++) write_word(a, 8'($urandom_range(0, 48)));
    run_layer("post_abort", 1'b0);

    rd_addr = 8'd4; #1;
    check("rd_oob4", 32'(data_out), 32'd0);
    rd_addr = 8'hFF; #1;
    check("rd_oobff", 32'(data_out), 32'd0);
    write_word(8'h40, 8'h55);
    run_layer("ignored_wr", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
